// File: rtl/gesture_key_filter_if.sv
// Frame-rate key handshake between the gesture front end (master) and the key filter (slave).
interface gesture_key_filter_if;
  logic       valid_in;
  logic [1:0] key_in;
  logic       active_in;
  logic [1:0] key_out;
  logic       key_valid_out;
  logic       held_out;
  logic [1:0] state_out;

  modport master (
    output valid_in, key_in, active_in,
    input  key_out, key_valid_out, held_out, state_out
  );

  modport slave (
    input  valid_in, key_in, active_in,
    output key_out, key_valid_out, held_out, state_out
  );
endinterface

// File: rtl/gesture_key_filter.sv
// Debounces a per-frame gesture direction into single-cycle press and auto-repeat events,
// with a release window so one sustained gesture never counts as two presses.
module gesture_key_filter #(
  parameter int unsigned STABLE_FRAMES  = 4,
  parameter int unsigned REPEAT_FRAMES  = 15,
  parameter int unsigned RELEASE_FRAMES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  gesture_key_filter_if.slave  bus
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned RCNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMING  = 2'b01,
    LOCKED  = 2'b10,
    RELEASE = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]        cand_q, cand_d;
  logic [1:0]        key_q, key_d;
  logic              kv_q, kv_d;
  logic              held_q, held_d;

  logic [CNT_W:0]    cnt_inc;
  logic [RCNT_W:0]   rcnt_inc;
  logic [CNT_W-1:0]  cnt_sat;
  logic              same_key;
  logic              fire;

  assign cnt_inc  = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
  assign rcnt_inc = (RCNT_W+1)'(rcnt_q) + (RCNT_W+1)'(1);
  assign cnt_sat  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign same_key = (bus.key_in == cand_q);

  // Next-state decode; only frame strobes advance the machine, the pulse always self-clears.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    cand_d  = cand_q;
    fire    = 1'b0;
    if (bus.valid_in) begin
      unique case (state_q)
        IDLE: begin
          if (bus.active_in) begin
            cand_d = bus.key_in;
            cnt_d  = CNT_W'(1);
            if (STABLE_FRAMES == 1) begin
              state_d = LOCKED;
              cnt_d   = '0;
              fire    = 1'b1;
            end else begin
              state_d = ARMING;
            end
          end
        end
        ARMING: begin
          if (!bus.active_in) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (same_key) begin
            if (cnt_inc == (CNT_W+1)'(STABLE_FRAMES)) begin
              state_d = LOCKED;
              cnt_d   = '0;
              fire    = 1'b1;
            end else begin
              cnt_d = cnt_sat;
            end
          end else begin
            cand_d = bus.key_in;
            cnt_d  = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (bus.active_in && same_key) begin
            if (REPEAT_FRAMES != 0) begin
              if (cnt_inc == (CNT_W+1)'(REPEAT_FRAMES)) begin
                cnt_d = '0;
                fire  = 1'b1;
              end else begin
                cnt_d = cnt_sat;
              end
            end
          end else if (bus.active_in) begin
            // Direction change while held: force a release before a new key can arm.
            state_d = RELEASE;
            rcnt_d  = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
            if (RELEASE_FRAMES == 1) begin
              state_d = IDLE;
              rcnt_d  = '0;
            end else begin
              state_d = RELEASE;
              rcnt_d  = RCNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (bus.active_in) begin
            rcnt_d = '0;
          end else if (rcnt_inc == (RCNT_W+1)'(RELEASE_FRAMES)) begin
            state_d = IDLE;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode lands in registers alongside the state.
  always_comb begin
    key_d  = fire ? cand_d : key_q;
    kv_d   = fire;
    held_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      cand_q  <= '0;
      key_q   <= '0;
      kv_q    <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      kv_q    <= kv_d;
      held_q  <= held_d;
    end
  end

  assign bus.key_out       = key_q;
  assign bus.key_valid_out = kv_q;
  assign bus.held_out      = held_q;
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_gesture_key_filter.sv
// Bench for gesture_key_filter: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized gesture segments.
module tb_gesture_key_filter;

  localparam int unsigned STABLE  = 4;
  localparam int unsigned REPEAT  = 15;
  localparam int unsigned RELEASE = 2;

  logic clk_in = 1'b0;
  logic rst_in;

  gesture_key_filter_if bus ();

  gesture_key_filter #(
    .STABLE_FRAMES (STABLE),
    .REPEAT_FRAMES (REPEAT),
    .RELEASE_FRAMES(RELEASE)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;

  // Reference model: mode 0 hunting for a stable key, 1 key held, 2 waiting for release.
  int         m_mode, m_run, m_rep, m_quiet;
  logic [1:0] m_cand;
  logic [1:0] exp_key;
  bit         exp_valid, exp_held, m_ok;
  int         exp_state;
  bit         prev_kv;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_fire();
    exp_valid = 1'b1;
    exp_key   = m_cand;
  endtask

  task automatic model_frame(input bit act, input logic [1:0] k);
    case (m_mode)
      0: begin
        if (!act) m_run = 0;
        else begin
          if (m_run > 0 && k == m_cand) m_run++;
          else begin
            m_cand = k;
            m_run  = 1;
          end
          if (m_run == int'(STABLE)) begin
            model_fire();
            m_mode = 1;
            m_rep  = 0;
            m_run  = 0;
          end
        end
      end
      1: begin
        if (act && k == m_cand) begin
          m_rep++;
          if (REPEAT != 0 && (m_rep % int'(REPEAT)) == 0) model_fire();
        end else if (act) begin
          m_mode  = 2;
          m_quiet = 0;
        end else begin
          m_quiet = 1;
          m_mode  = (m_quiet == int'(RELEASE)) ? 0 : 2;
          m_run   = 0;
        end
      end
      default: begin
        if (act) m_quiet = 0;
        else m_quiet++;
        if (m_quiet == int'(RELEASE)) begin
          m_mode = 0;
          m_run  = 0;
        end
      end
    endcase
  endtask

  task automatic frame(input bit act, input logic [1:0] k, input bit rst = 1'b0, input int gap = 0);
    @(negedge clk_in);
    bus.valid_in  = 1'b1;
    bus.active_in = act;
    bus.key_in    = k;
    rst_in        = rst;
    @(negedge clk_in);
    bus.valid_in  = 1'b0;
    rst_in        = 1'b0;
    bus.key_in    = 2'($urandom);
    bus.active_in = 1'($urandom);
    repeat (gap) @(negedge clk_in);
  endtask

  task automatic frames(input int n, input bit act, input logic [1:0] k);
    for (int i = 0; i < n; i++) frame(act, k);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in       = 1'b1;
    bus.valid_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  int base;

  initial begin
    rst_in        = 1'b1;
    bus.valid_in  = 1'b0;
    bus.key_in    = 2'b00;
    bus.active_in = 1'b0;
    m_ok          = 1'b0;
    prev_kv       = 1'b0;

    fork
      // Model advances on the same edge the DUT samples.
      forever begin
        @(posedge clk_in);
        if (rst_in) begin
          m_mode = 0; m_run = 0; m_rep = 0; m_quiet = 0;
          m_cand = 2'b00; exp_key = 2'b00; exp_valid = 1'b0;
          m_ok = 1'b1;
        end else begin
          exp_valid = 1'b0;
          if (bus.valid_in) model_frame(bus.active_in, bus.key_in);
        end
        exp_held  = (m_mode == 1);
        exp_state = (m_mode == 1) ? 2 : (m_mode == 2) ? 3 : (m_run > 0) ? 1 : 0;
      end
      forever begin
        @(negedge clk_in);
        if (m_ok) begin
          chk("key_out", int'(bus.key_out), int'(exp_key));
          chk("key_valid_out", int'(bus.key_valid_out), int'(exp_valid));
          chk("held_out", int'(bus.held_out), int'(exp_held));
          chk("state_out", int'(bus.state_out), exp_state);
          chk("pulse_back_to_back", int'(prev_kv && bus.key_valid_out), 0);
          prev_kv = bus.key_valid_out;
        end
      end
      forever begin
        @(posedge clk_in);
        #1;
        if (bus.key_valid_out === 1'b1) pulse_cnt++;
      end
    join_none

    // Stable 10 for four frames gives one press.
    do_reset();
    chk("rst_state", int'(bus.state_out), 0);
    chk("rst_key", int'(bus.key_out), 0);
    base = pulse_cnt;
    frames(3, 1'b1, 2'b10);
    chk("t1_no_early_pulse", pulse_cnt - base, 0);
    chk("t1_pin_model_state", exp_state, 1);
    @(negedge clk_in);
    bus.valid_in = 1'b1; bus.active_in = 1'b1; bus.key_in = 2'b10;
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    chk("t1_pulse_now", int'(bus.key_valid_out), 1);
    chk("t1_key", int'(bus.key_out), 2);
    chk("t1_held", int'(bus.held_out), 1);
    chk("t1_pin_model_valid", int'(exp_valid), 1);

    // Switch at frame four restarts the count.
    do_reset();
    base = pulse_cnt;
    frames(3, 1'b1, 2'b01);
    frames(3, 1'b1, 2'b11);
    chk("t2_no_pulse_yet", pulse_cnt - base, 0);
    frame(1'b1, 2'b11);
    chk("t2_one_pulse", pulse_cnt - base, 1);
    chk("t2_key", int'(bus.key_out), 3);

    // Auto-repeat every fifteen held frames.
    do_reset();
    base = pulse_cnt;
    frames(4, 1'b1, 2'b00);
    frames(14, 1'b1, 2'b00);
    chk("t3_before_repeat", pulse_cnt - base, 1);
    frame(1'b1, 2'b00);
    chk("t3_first_repeat", pulse_cnt - base, 2);
    frames(15, 1'b1, 2'b00);
    chk("t3_total", pulse_cnt - base, 3);
    chk("t3_key", int'(bus.key_out), 0);

    // Release window restarted by an active frame, then re-arm.
    do_reset();
    base = pulse_cnt;
    frames(4, 1'b1, 2'b01);
    frame(1'b0, 2'b00);
    chk("t4_release", int'(bus.state_out), 3);
    frame(1'b1, 2'b01);
    chk("t4_still_release", int'(bus.state_out), 3);
    frame(1'b0, 2'b00);
    chk("t4_release_one_quiet", int'(bus.state_out), 3);
    frame(1'b0, 2'b00);
    chk("t4_idle", int'(bus.state_out), 0);
    chk("t4_pin_model_idle", exp_state, 0);
    frames(3, 1'b1, 2'b01);
    chk("t4_no_early_second", pulse_cnt - base, 1);
    frame(1'b1, 2'b01);
    chk("t4_second_press", pulse_cnt - base, 2);

    // Direction change while locked must go through release and re-arm.
    do_reset();
    base = pulse_cnt;
    frames(4, 1'b1, 2'b10);
    frame(1'b1, 2'b11);
    chk("t5_state_release", int'(bus.state_out), 3);
    chk("t5_no_event", pulse_cnt - base, 1);
    frames(2, 1'b0, 2'b00);
    frames(3, 1'b1, 2'b11);
    chk("t5_still_no_11", pulse_cnt - base, 1);
    frame(1'b1, 2'b11);
    chk("t5_11_fires", pulse_cnt - base, 2);
    chk("t5_key", int'(bus.key_out), 3);

    // Reset coincident with the qualifying frame wins.
    do_reset();
    base = pulse_cnt;
    frames(3, 1'b1, 2'b10);
    frame(1'b1, 2'b10, 1'b1);
    chk("t6_no_pulse", pulse_cnt - base, 0);
    chk("t6_key_rst", int'(bus.key_out), 0);
    chk("t6_held_rst", int'(bus.held_out), 0);
    chk("t6_state_rst", int'(bus.state_out), 0);
    frames(3, 1'b1, 2'b10);
    chk("t6_restart_no_pulse", pulse_cnt - base, 0);
    chk("t6_arming", int'(bus.state_out), 1);

    // Randomized gesture segments with noise, gaps and occasional reset.
    for (int s = 0; s < 120; s++) begin
      bit         seg_act;
      logic [1:0] seg_key;
      int         len;
      seg_act = ($urandom_range(0, 3) != 0);
      seg_key = 2'($urandom);
      len     = $urandom_range(1, 40);
      for (int f = 0; f < len; f++) begin
        bit         a;
        logic [1:0] k;
        a = seg_act;
        k = seg_key;
        if ($urandom_range(0, 99) < 8) begin
          a = 1'($urandom);
          k = 2'($urandom);
        end
        frame(a, k, ($urandom_range(0, 299) == 0), $urandom_range(0, 2));
      end
    end

    repeat (3) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
